di_dispatch_queue: RTL

//  Decoded-instruction buffer sitting directly downstream of the dynamic decoder.

---
 rtl/di_dispatch_queue.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/di_dispatch_queue.sv
// Decoded-instruction dispatch queue, sitting between the dynamic decoder and the
// issue stage. Entries are buffered in order. A decoder fault turns into a precise
// stop: nothing younger than the faulting entry is accepted or issued, and only a
// flush releases the stop.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   di_i         decoded instruction in; di_i.valid requests a push
//   di_i_ready   queue accepts di_i this cycle
//   di_o         head entry; di_o.valid means the head is presented
//   di_o_ready   issue stage consumes the head this cycle
//   flush_i      discard all entries and return to RUN
//   fault_o      one-cycle pulse: the faulting entry has just issued
//   fault_id_o   id of that entry, held until flush or reset
//   count_o      number of stored entries

package C;
  typedef logic [7:0] id_t;
  typedef struct packed {
    logic        valid;
    logic        fault;
    id_t         id;
    logic [15:0] instr;
  } di_t;
endpackage

module di_dispatch_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  C::di_t                     di_i,
  output logic                       di_i_ready,
  output C::di_t                     di_o,
  input  logic                       di_o_ready,
  input  logic                       flush_i,
  output logic                       fault_o,
  output C::id_t                     fault_id_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

  state_e           state_q, state_d;
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fault_q, fault_d;
  C::id_t           fault_id_q, fault_id_d;
  C::di_t           mem_q [DEPTH];

  logic             full, empty, push, pop;
  logic [PTR_W-1:0] wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[PTR_W-1:0];
  assign rd_idx = rd_ptr_q[PTR_W-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

  // Handshake outputs. Ready deliberately ignores di_o_ready: a full queue
  // refuses even when the head is leaving in the same cycle.
  always_comb begin
    di_i_ready = !rst && !full && (state_q == StRun) && !flush_i;
    di_o       = mem_q[rd_idx];
    di_o.valid = !rst && !empty && (state_q != StHalt);
    push       = di_i.valid && di_i_ready;
    // di_o.valid stays driven during flush, but the consume is ignored.
    pop        = di_o.valid && di_o_ready && !flush_i;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fault_d    = 1'b0;
    fault_id_d = fault_id_q;

    if (flush_i) begin
      // Flush wins over everything, including a faulting pop in this cycle.
      state_d    = StRun;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      fault_id_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = CNT_W'(wr_ptr_d - rd_ptr_d);

      unique case (state_q)
        StRun: begin
          if (push && di_i.fault) begin
            // Popping the pushed entry in the same cycle would need a bypass path.
            state_d = (pop && (rd_ptr_q == wr_ptr_q)) ? StHalt : StDrain;
          end
        end
        StDrain: begin
          if (pop && di_o.fault) begin
            state_d    = StHalt;
            fault_d    = 1'b1;
            fault_id_d = di_o.id;
          end
        end
        StHalt: ;
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fault_q    <= 1'b0;
      fault_id_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fault_q    <= fault_d;
      fault_id_q <= fault_id_d;
    end
  end

  // Storage needs no reset; the pointers define which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= di_i;
  end

  assign fault_o    = fault_q;
  assign fault_id_o = fault_id_q;
  assign count_o    = count_q;

  // A faulting entry can never issue in the cycle it is pushed (no flow-through).
  a_no_fault_bypass: assert property (@(posedge clk) disable iff (rst)
    !(push && di_i.fault && pop && (rd_ptr_q == wr_ptr_q)));

  a_fault_pulse: assert property (@(posedge clk) disable iff (rst)
    !(fault_q && fault_d));

endmodule
